regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 32-entry register file (array of 32-bit Register instances) among NUM_REQ write-back sources (e.g. ALU, load unit, multiplier, CSR path).
- Selects one requester per cycle, round-robin, and drives a registered write enable, address and data into the register file.
- The register file sits downstream; the requesting pipeline stages sit upstream.

Parameters:
- NUM_REQ, 4, number of write-back requesters; power of two, 2..8.
- DATA_W, 32, register data width.
- ADDR_W, 5, register index width; index 0 is the hardwired zero register.
- IDX_W, $clog2(NUM_REQ), width of requester index (derived, not overridable).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester write request; bit i belongs to requester i.
- req_addr  input  NUM_REQ*ADDR_W  destination index; requester i at bits [i*ADDR_W +: ADDR_W].
- req_data  input  NUM_REQ*DATA_W  write data; requester i at bits [i*DATA_W +: DATA_W].
- stall  input  1  register file not accepting writes this cycle; no grant issued.
- gnt  output  NUM_REQ  one-hot grant, combinational, same cycle as acceptance.
- rf_write  output  1  registered write strobe to the register file.
- rf_addr  output  ADDR_W  registered write index.
- rf_data  output  DATA_W  registered write data.
- last_id  output  IDX_W  registered index of the most recently granted requester.

Behaviour:
- State: round-robin pointer ptr (IDX_W bits), plus registered rf_write, rf_addr, rf_data and last_id.
- Reset (reset=1 at a clock edge):
  - ptr=0, rf_write=0, rf_addr=0, rf_data=0, last_id=0.
  - gnt is forced to 0 in every cycle where reset=1, regardless of req.
  - A reset arriving while a write is pending in the output register cancels that write: rf_write=0 next cycle.
- Arbitration, evaluated each cycle with reset=0 and stall=0:
  - Scan req starting at index ptr, then ptr+1, ..., wrapping modulo NUM_REQ. The first set bit is the winner w.
  - gnt = one-hot(w), combinational from req, ptr, stall and reset. At most one gnt bit is ever high.
- Acceptance edge, when a winner exists:
  - rf_addr <= addr[w], rf_data <= data[w], last_id <= w.
  - ptr <= (w+1) mod NUM_REQ.
  - rf_write <= 1 if addr[w] != 0; rf_write <= 0 if addr[w] == 0. A write to r0 is still granted and consumed; it just never reaches the register file.
- Latency: request accepted in cycle N (gnt high) -> rf_write/rf_addr/rf_data valid in cycle N+1. The register file captures the data at the end of cycle N+1.
- No request, or stall=1:
  - gnt=0, rf_write <= 0.
  - ptr, rf_addr, rf_data and last_id hold their values.
- Requester handshake:
  - A requester holds req, addr and data stable until it sees its gnt bit high at a clock edge.
  - In the cycle after the grant it may deassert, or present a new request. Back-to-back grants to the same requester are allowed only when no other requester is active.
  - A requester may not withdraw req before it is granted. Withdrawing before grant is a protocol violation; the block does not check it.
- Fairness: with all NUM_REQ requesters continuously active, each is granted exactly once every NUM_REQ non-stalled cycles. No requester waits more than NUM_REQ-1 non-stalled grant cycles.
- Same-address conflict: two requesters targeting the same index are serialised in round-robin order, and the later grant's data is what remains in the register. Program ordering between sources is the upstream pipeline's responsibility.
- stall is sampled in the same cycle as req. Deasserting stall makes a grant possible that same cycle.
- Throughput: one write per non-stalled cycle. The block has no internal buffering beyond the output register.

Test Plan:
- Reset: hold reset 2 cycles with req=4'b1111 -> gnt=0, rf_write=0, rf_addr=0, rf_data=0, last_id=0 throughout. After release, first grant goes to requester 0.
- Single requester: req=4'b0100, addr2=5'd7, data2=32'hDEADBEEF -> gnt=4'b0100 in the same cycle. Next cycle rf_write=1, rf_addr=7, rf_data=DEADBEEF, last_id=2.
- Round-robin: req=4'b1111 held for 8 cycles, distinct addresses -> gnt sequence 0,1,2,3,0,1,2,3. rf_write=1 on cycles 1..8.
- Zero register: requester 1 alone with addr=0, data=32'h12345678 -> gnt=4'b0010, then rf_write=0 next cycle. ptr advances, so requesters 1 and 3 then both requesting gives requester 3 first.
- Stall: req=4'b0011 with stall=1 for 3 cycles -> gnt=0, rf_write=0, outputs hold. stall deasserts -> gnt=4'b0001 that cycle, then 4'b0010 the following cycle.
- Reset mid-operation: grant to requester 3 in cycle N, reset=1 in cycle N+1 -> rf_write=0 in N+2, ptr=0. Next arbitration with req=4'b1001 grants requester 0.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NUM_REQ write-back sources.
// A winner is picked each unstalled cycle; its address/data are registered toward the register file.

module regfile_write_arbiter_lane #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2,
  parameter int LANE    = 0
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               win
);
  // Lane wins when it requests and no requester closer to ptr (cyclically) also requests.
  always_comb begin
    logic [IDX_W-1:0] d_self;
    logic [IDX_W-1:0] d_j;
    logic             blocked;
    d_self  = IDX_W'(LANE) - ptr;
    d_j     = '0;
    blocked = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      d_j = IDX_W'(j) - ptr;
      if (req[j] && (d_j < d_self)) blocked = 1'b1;
    end
    win = req[LANE] && !blocked;
  end
endmodule

module regfile_write_arbiter #(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = 32,
  parameter  int ADDR_W  = 5,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      stall,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      rf_write,
  output logic [ADDR_W-1:0]         rf_addr,
  output logic [DATA_W-1:0]         rf_data,
  output logic [IDX_W-1:0]          last_id
);
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic [IDX_W-1:0]   ptr;
  logic [NUM_REQ-1:0] win;
  wr_t  [NUM_REQ-1:0] lane_wr;
  wr_t                sel_wr;
  logic [IDX_W-1:0]   w_idx;
  logic               accept;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign lane_wr[i] = '{addr: req_addr[i*ADDR_W +: ADDR_W], data: req_data[i*DATA_W +: DATA_W]};
    regfile_write_arbiter_lane #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W), .LANE(i)) u_lane (
      .req (req),
      .ptr (ptr),
      .win (win[i])
    );
  end

  assign gnt    = (reset || stall) ? '0 : win;
  assign accept = |gnt;

  // gnt is one-hot, so an OR-reduction acts as the select mux and encoder.
  always_comb begin
    sel_wr = '0;
    w_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_wr = sel_wr | lane_wr[i];
        w_idx  = w_idx | IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr      <= '0;
      rf_write <= 1'b0;
      rf_addr  <= '0;
      rf_data  <= '0;
      last_id  <= '0;
    end else if (accept) begin
      ptr      <= w_idx + IDX_W'(1);
      rf_write <= (sel_wr.addr != '0);
      rf_addr  <= sel_wr.addr;
      rf_data  <= sel_wr.data;
      last_id  <= w_idx;
    end else begin
      rf_write <= 1'b0;
    end
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios then constrained-random traffic,
// checked against a scan-from-pointer reference model.

module tb_regfile_write_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_data;
  logic              stall;
  logic [N-1:0]      gnt;
  logic              rf_write;
  logic [AW-1:0]     rf_addr;
  logic [DW-1:0]     rf_data;
  logic [IW-1:0]     last_id;

  int errors = 0;
  int checks = 0;

  int            m_ptr  = 0;
  logic          m_wr   = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  int            m_last = 0;
  int            last_w;

  regfile_write_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_data(req_data),
    .stall(stall), .gnt(gnt), .rf_write(rf_write), .rf_addr(rf_addr), .rf_data(rf_data),
    .last_id(last_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int winner();
    if (reset || stall) return -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  // One cycle: check gnt and registered outputs mid-cycle, then advance the model at the edge.
  task automatic step(input string tag, output int w);
    logic [N-1:0] eg;
    @(negedge clk);
    w  = winner();
    eg = (w < 0) ? '0 : N'(1 << w);
    chk({tag, ".gnt"}, 64'(gnt), 64'(eg));
    chk({tag, ".rf_write"}, 64'(rf_write), 64'(m_wr));
    chk({tag, ".rf_addr"}, 64'(rf_addr), 64'(m_addr));
    chk({tag, ".rf_data"}, 64'(rf_data), 64'(m_data));
    chk({tag, ".last_id"}, 64'(last_id), 64'(m_last));
    @(posedge clk);
    if (reset) begin
      m_ptr = 0; m_wr = 1'b0; m_addr = '0; m_data = '0; m_last = 0;
    end else if (w >= 0) begin
      m_addr = req_addr[w*AW +: AW];
      m_data = req_data[w*DW +: DW];
      m_wr   = (m_addr != '0);
      m_last = w;
      m_ptr  = (w + 1) % N;
    end else begin
      m_wr = 1'b0;
    end
    #1;
  endtask

  initial begin
    logic [N-1:0] pend;
    int hold_id;

    reset = 1'b1; stall = 1'b0; req = 4'b1111;
    req_addr = '0; req_data = '0;
    for (int i = 0; i < N; i++) set_req(i, AW'(i + 1), DW'(32'hA000_0000 + i));

    step("rst0", last_w);
    step("rst1", last_w);
    reset = 1'b0;
    step("rst_release", last_w);
    chk("first_grant_id", 64'(last_id), 64'd0);
    chk("first_grant_addr", 64'(rf_addr), 64'd1);

    req = 4'b0100; set_req(2, 5'd7, 32'hDEADBEEF);
    step("single", last_w);
    chk("single.rf_write", 64'(rf_write), 64'd1);
    chk("single.rf_addr", 64'(rf_addr), 64'd7);
    chk("single.rf_data", 64'(rf_data), 64'hDEADBEEF);
    chk("single.last_id", 64'(last_id), 64'd2);

    reset = 1'b1; req = '0;
    step("rr_rst", last_w);
    reset = 1'b0; req = 4'b1111;
    for (int i = 0; i < N; i++) set_req(i, AW'(8 + i), DW'(32'h5500_0000 + i));
    for (int c = 0; c < 8; c++) begin
      step("rr", last_w);
      chk("rr.order", 64'(last_id), 64'(c % N));
      chk("rr.write", 64'(rf_write), 64'd1);
    end

    req = 4'b0010; set_req(1, 5'd0, 32'h12345678);
    step("zero", last_w);
    chk("zero.rf_write", 64'(rf_write), 64'd0);
    chk("zero.last_id", 64'(last_id), 64'd1);
    req = 4'b1010; set_req(1, 5'd3, 32'h0000_0013);
    step("zero_next", last_w);
    chk("zero_next.id", 64'(last_id), 64'd3);
    step("zero_next2", last_w);
    chk("zero_next2.id", 64'(last_id), 64'd1);

    req = 4'b0011; stall = 1'b1;
    hold_id = int'(last_id);
    for (int c = 0; c < 3; c++) begin
      step("stall", last_w);
      chk("stall.rf_write", 64'(rf_write), 64'd0);
      chk("stall.hold_id", 64'(last_id), 64'(hold_id));
    end
    stall = 1'b0;
    step("unstall0", last_w);
    chk("unstall0.id", 64'(last_id), 64'd0);
    req = 4'b0010;
    step("unstall1", last_w);
    chk("unstall1.id", 64'(last_id), 64'd1);

    req = 4'b1000; set_req(3, 5'd21, 32'hCAFE0003);
    step("mid_grant", last_w);
    chk("mid_grant.id", 64'(last_id), 64'd3);
    reset = 1'b1; req = '0;
    step("mid_reset", last_w);
    chk("mid_reset.rf_write", 64'(rf_write), 64'd0);
    reset = 1'b0; req = 4'b1001;
    step("mid_after", last_w);
    chk("mid_after.id", 64'(last_id), 64'd0);

    // Random traffic: each requester holds its request until granted.
    pend = req;
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 49) == 0);
      stall = ($urandom_range(0, 4) == 0);
      req   = pend;
      step("rand", last_w);
      if (last_w >= 0) pend[last_w] = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          set_req(i, ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom),
                  DW'($urandom));
        end
      end
    end
    reset = 1'b0; stall = 1'b0; req = '0;
    step("drain", last_w);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
